// File: rtl/spike_pkg.sv
// +----------------------------------------------------------------------------+
// | spike_pkg : shared types and constants for the spike arbiter               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package spike_pkg;

   localparam int DROP_CNT_W          = 8;
   localparam int N_SRC_DEFAULT       = 4;
   localparam int HOLD_CYCLES_DEFAULT = 2;
   localparam int HOLD_CNT_W          = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OFFER = 2'd1,
      HOLD  = 2'd2
   } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_select.sv
// +----------------------------------------------------------------------------+
// | rr_select : combinational round-robin picker, searches from last_grant+1   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_select
   import spike_pkg::*;
#(
   parameter int N_SRC = N_SRC_DEFAULT,
   parameter int ID_W  = $clog2(N_SRC)
) (
   input  logic [N_SRC-1:0] pending_i,
   input  logic [ID_W-1:0]  last_grant_i,
   output logic             any_o,
   output logic [ID_W-1:0]  sel_id_o
);

   // Walk offsets from farthest to nearest so the nearest set bit wins.
   always_comb begin
      int idx;
      any_o    = |pending_i;
      sel_id_o = '0;
      idx      = 0;
      for (int off = N_SRC; off >= 1; off--) begin
         idx = (int'(last_grant_i) + off) % N_SRC;
         if (pending_i[idx]) begin
            sel_id_o = ID_W'(idx);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/spike_arbiter.sv
// +----------------------------------------------------------------------------+
// | spike_arbiter : round-robin spike-to-synapse scheduler with hold-off.      |
// | Optional drop counter enabled by SPIKE_ARB_DROP_CNT_EN.  Rev 1.0           |
// +----------------------------------------------------------------------------+
`default_nettype none

module spike_arbiter
   import spike_pkg::*;
#(
   parameter int N_SRC       = N_SRC_DEFAULT,
   parameter int ID_W        = $clog2(N_SRC),
   parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_SRC-1:0]      spike_in,
   output logic                  evt_valid,
   output logic [ID_W-1:0]       evt_id,
   input  logic                  evt_ready,
   output logic                  busy,
   output logic [DROP_CNT_W-1:0] drop_count
);

   arb_state_t            state_q, state_d;
   logic [N_SRC-1:0]      pending_q, pending_d;
   logic [ID_W-1:0]       last_grant_q, last_grant_d;
   logic [ID_W-1:0]       evt_id_q, evt_id_d;
   logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic                  valid_q;
   logic                  busy_q;

   logic                  rr_any;
   logic [ID_W-1:0]       rr_sel;
   logic                  accept;
   logic [N_SRC-1:0]      clear_vec;

   rr_select #(
      .N_SRC (N_SRC),
      .ID_W  (ID_W)
   ) u_rr_select (
      .pending_i    (pending_q),
      .last_grant_i (last_grant_q),
      .any_o        (rr_any),
      .sel_id_o     (rr_sel)
   );

   always_comb begin
      state_d      = state_q;
      evt_id_d     = evt_id_q;
      last_grant_d = last_grant_q;
      hold_cnt_d   = hold_cnt_q;
      accept       = 1'b0;
      case (state_q)
         IDLE: begin
            if (rr_any) begin
               evt_id_d = rr_sel;
               state_d  = OFFER;
            end
         end
         OFFER: begin
            if (evt_ready) begin
               accept       = 1'b1;
               last_grant_d = evt_id_q;
               hold_cnt_d   = HOLD_CNT_W'(HOLD_CYCLES);
               state_d      = (HOLD_CYCLES == 0) ? IDLE : HOLD;
            end
         end
         HOLD: begin
            hold_cnt_d = hold_cnt_q - HOLD_CNT_W'(1);
            if (hold_cnt_q == HOLD_CNT_W'(1)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A new spike in the same cycle as its handshake re-arms the bit.
   always_comb begin
      clear_vec = '0;
      if (accept) begin
         clear_vec[evt_id_q] = 1'b1;
      end
      pending_d = (pending_q & ~clear_vec) | spike_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         pending_q    <= '0;
         last_grant_q <= ID_W'(N_SRC - 1);
         evt_id_q     <= '0;
         hold_cnt_q   <= '0;
         valid_q      <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         last_grant_q <= last_grant_d;
         evt_id_q     <= evt_id_d;
         hold_cnt_q   <= hold_cnt_d;
         valid_q      <= (state_d == OFFER);
         busy_q       <= (state_d != IDLE);
      end
   end

   assign evt_valid = valid_q;
   assign evt_id    = evt_id_q;
   assign busy      = busy_q;

`ifdef SPIKE_ARB_DROP_CNT_EN
   logic [N_SRC-1:0]      drop_vec;
   logic [DROP_CNT_W:0]   drop_sum;
   logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   // Sum cannot exceed 2*2^DROP_CNT_W, so the top bit flags saturation.
   always_comb begin
      drop_vec = spike_in & pending_q & ~clear_vec;
      drop_sum = {1'b0, drop_cnt_q};
      for (int i = 0; i < N_SRC; i++) begin
         drop_sum = drop_sum + (DROP_CNT_W + 1)'(drop_vec[i]);
      end
      drop_cnt_d = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_count = drop_cnt_q;
`else
   assign drop_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spike_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_spike_arbiter : table-driven bench for spike_arbiter (N_SRC=4, HOLD=2)  |
// | plus a HOLD_CYCLES=0 instance.  Rev 1.0                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_spike_arbiter;
   import spike_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] spike_in;
   logic       evt_ready;
   logic       evt_valid;
   logic [1:0] evt_id;
   logic       busy;
   logic [7:0] drop_count;

   logic       h0_valid;
   logic [1:0] h0_id;
   logic       h0_busy;
   logic [7:0] h0_drop;

`ifdef SPIKE_ARB_DROP_CNT_EN
   localparam bit DROP_EN = 1'b1;
`else
   localparam bit DROP_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   spike_arbiter #(.N_SRC(4), .HOLD_CYCLES(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .spike_in   (spike_in),
      .evt_valid  (evt_valid),
      .evt_id     (evt_id),
      .evt_ready  (evt_ready),
      .busy       (busy),
      .drop_count (drop_count)
   );

   spike_arbiter #(.N_SRC(4), .HOLD_CYCLES(0)) dut_h0 (
      .clk        (clk),
      .reset      (reset),
      .spike_in   (spike_in),
      .evt_valid  (h0_valid),
      .evt_id     (h0_id),
      .evt_ready  (evt_ready),
      .busy       (h0_busy),
      .drop_count (h0_drop)
   );

   typedef struct packed {
      logic       rst;
      logic [3:0] spk;
      logic       rdy;
      logic       ev;
      logic [1:0] id;
      logic       bz;
      logic [7:0] dc;
   } vec_t;

   vec_t vecs[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic add(input logic rst, input logic [3:0] spk, input logic rdy,
                      input logic ev, input logic [1:0] id, input logic bz,
                      input logic [7:0] dc);
      vec_t v;
      v.rst = rst; v.spk = spk; v.rdy = rdy;
      v.ev  = ev;  v.id  = id;  v.bz  = bz; v.dc = dc;
      vecs.push_back(v);
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   // Inputs held for one clock; outputs sampled 1 ns after the edge.
   task automatic step(input logic rst, input logic [3:0] spk, input logic rdy);
      reset     = rst;
      spike_in  = spk;
      evt_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] d1;
      logic [7:0] exp_dc;
      reset     = 1'b1;
      spike_in  = '0;
      evt_ready = 1'b0;
      d1        = DROP_EN ? 8'd1 : 8'd0;

      //   rst spk    rdy  ev id bz dc
      // single spike on source 0
      add(1, 4'h0, 0,   0, 0, 0, 0);
      add(0, 4'h1, 1,   0, 0, 0, 0);
      add(0, 4'h0, 1,   1, 0, 1, 0);
      add(0, 4'h0, 1,   0, 0, 1, 0);
      add(0, 4'h0, 1,   0, 0, 1, 0);
      add(0, 4'h0, 1,   0, 0, 0, 0);
      add(0, 4'h0, 1,   0, 0, 0, 0);
      // fairness: all four at once, from reset
      add(1, 4'h0, 0,   0, 0, 0, 0);
      add(0, 4'hF, 1,   0, 0, 0, 0);
      add(0, 4'h0, 1,   1, 0, 1, 0);
      add(0, 4'h0, 1,   0, 0, 1, 0);
      add(0, 4'h0, 1,   0, 0, 1, 0);
      add(0, 4'h0, 1,   0, 0, 0, 0);
      add(0, 4'h0, 1,   1, 1, 1, 0);
      add(0, 4'h0, 1,   0, 1, 1, 0);
      add(0, 4'h0, 1,   0, 1, 1, 0);
      add(0, 4'h0, 1,   0, 1, 0, 0);
      add(0, 4'h0, 1,   1, 2, 1, 0);
      add(0, 4'h0, 1,   0, 2, 1, 0);
      add(0, 4'h0, 1,   0, 2, 1, 0);
      add(0, 4'h0, 1,   0, 2, 0, 0);
      add(0, 4'h0, 1,   1, 3, 1, 0);
      add(0, 4'h0, 1,   0, 3, 1, 0);
      add(0, 4'h0, 1,   0, 3, 1, 0);
      add(0, 4'h0, 1,   0, 3, 0, 0);
      // backpressure with a repeated spike on source 2
      add(0, 4'h4, 0,   0, 3, 0, 0);
      add(0, 4'h0, 0,   1, 2, 1, 0);
      add(0, 4'h4, 0,   1, 2, 1, d1);
      add(0, 4'h0, 0,   1, 2, 1, d1);
      add(0, 4'h0, 0,   1, 2, 1, d1);
      add(0, 4'h0, 0,   1, 2, 1, d1);
      add(0, 4'h0, 1,   0, 2, 1, d1);
      add(0, 4'h0, 1,   0, 2, 1, d1);
      add(0, 4'h0, 1,   0, 2, 0, d1);
      // collision: source 1 spikes during its own handshake
      add(0, 4'h2, 0,   0, 2, 0, d1);
      add(0, 4'h1, 0,   1, 1, 1, d1);
      add(0, 4'hA, 1,   0, 1, 1, d1);
      add(0, 4'h0, 1,   0, 1, 1, d1);
      add(0, 4'h0, 1,   0, 1, 0, d1);
      add(0, 4'h0, 1,   1, 3, 1, d1);
      add(0, 4'h0, 1,   0, 3, 1, d1);
      add(0, 4'h0, 1,   0, 3, 1, d1);
      add(0, 4'h0, 1,   0, 3, 0, d1);
      add(0, 4'h0, 1,   1, 0, 1, d1);
      add(0, 4'h0, 1,   0, 0, 1, d1);
      add(0, 4'h0, 1,   0, 0, 1, d1);
      add(0, 4'h0, 1,   0, 0, 0, d1);
      add(0, 4'h0, 1,   1, 1, 1, d1);
      add(0, 4'h0, 1,   0, 1, 1, d1);
      add(0, 4'h0, 1,   0, 1, 1, d1);
      add(0, 4'h0, 1,   0, 1, 0, d1);
      // reset mid-OFFER with three pending sources
      add(0, 4'h7, 0,   0, 1, 0, d1);
      add(0, 4'h0, 0,   1, 2, 1, d1);
      add(1, 4'h0, 1,   0, 0, 0, 0);
      add(0, 4'h0, 1,   0, 0, 0, 0);
      add(0, 4'h0, 1,   0, 0, 0, 0);
      add(0, 4'h8, 1,   0, 0, 0, 0);
      add(0, 4'h0, 1,   1, 3, 1, 0);
      add(0, 4'h0, 1,   0, 3, 1, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst, vecs[i].spk, vecs[i].rdy);
         check($sformatf("vec%0d {valid,id,busy,drop}", i),
               32'({evt_valid, evt_id, busy, drop_count}),
               32'({vecs[i].ev, vecs[i].id, vecs[i].bz, vecs[i].dc}));
      end

      // saturation: source 0 spiking continuously under backpressure
      step(1, 4'h0, 0);
      for (int n = 1; n <= 301; n++) begin
         step(0, 4'h1, 0);
         if (n == 11 || n == 256 || n == 257 || n == 301) begin
            exp_dc = (n - 1 > 255) ? 8'd255 : 8'(n - 1);
            if (!DROP_EN) exp_dc = 8'd0;
            check($sformatf("sat_drop_n%0d", n), 32'(drop_count), 32'(exp_dc));
         end
      end
      check("sat_offer {valid,id}", 32'({evt_valid, evt_id}), 32'({1'b1, 2'd0}));
      step(0, 4'h0, 1);
      check("sat_release {valid,busy}", 32'({evt_valid, busy}), 32'({1'b0, 1'b1}));

      // HOLD_CYCLES=0: exactly one low cycle between back-to-back offers
      step(1, 4'h0, 1);
      check("h0_reset {valid,id,busy}", 32'({h0_valid, h0_id, h0_busy}), 32'({1'b0, 2'd0, 1'b0}));
      step(0, 4'h3, 1);
      check("h0_pend {valid,id,busy}", 32'({h0_valid, h0_id, h0_busy}), 32'({1'b0, 2'd0, 1'b0}));
      step(0, 4'h0, 1);
      check("h0_offer0 {valid,id,busy}", 32'({h0_valid, h0_id, h0_busy}), 32'({1'b1, 2'd0, 1'b1}));
      step(0, 4'h0, 1);
      check("h0_gap {valid,id,busy}", 32'({h0_valid, h0_id, h0_busy}), 32'({1'b0, 2'd0, 1'b0}));
      step(0, 4'h0, 1);
      check("h0_offer1 {valid,id,busy}", 32'({h0_valid, h0_id, h0_busy}), 32'({1'b1, 2'd1, 1'b1}));
      step(0, 4'h0, 1);
      check("h0_done {valid,id,busy}", 32'({h0_valid, h0_id, h0_busy}), 32'({1'b0, 2'd1, 1'b0}));
      check("h0_drop", 32'(h0_drop), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
